bidir_transceiver: RTL and testbench
====================================

# bidir_transceiver

Parametrised, clocked bidirectional bus transceiver between two WIDTH-bit tri-state ports `a` and `b`. Direction and enable are sampled on the clock. Every direction reversal or disable passes through a guaranteed bus-turnaround gap in which both sides are high-Z, so the two drivers never contend. It is the registered, multi-bit successor of the single-bit enable-steered bidirectional buffer and sits between shared bus segments in the combinational/bus-interface library.

## Interface
- `WIDTH`, default 8: data width of `a` and `b`; minimum 1.
- `TURNAROUND`, default 2: number of clock cycles both ports are high-Z after leaving a driving state; minimum 1.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `en`  input  1  transfer enable, sampled on `clk`.
- `dir`  input  1  requested direction, sampled on `clk`: 1 = a→b (drive `b`), 0 = b→a (drive `a`).
- `a`  inout  WIDTH  port A; driven only in state B2A, else high-Z.
- `b`  inout  WIDTH  port B; driven only in state A2B, else high-Z.
- `a_oe`  output  1  registered; 1 while the block drives `a`.
- `b_oe`  output  1  registered; 1 while the block drives `b`.
- `busy`  output  1  registered; 1 during the turnaround gap.

## Operation
- **States**: IDLE, A2B, B2A, TURN. A TURN counter is $clog2(TURNAROUND+1) bits wide.
- **Data registers**:
  - `q_ab` captures `a` on every rising edge.
  - `q_ba` captures `b` on every rising edge.
  - `b` = `q_ab` when state = A2B, else all-Z.
  - `a` = `q_ba` when state = B2A, else all-Z.
  - No combinational path exists from `a` to `b`.
- **Output decode**: `b_oe` = (state==A2B), `a_oe` = (state==B2A), `busy` = (state==TURN). The decodes are taken directly from the state register, so there is no glitching.
- **IDLE**:
  - `en`=1, `dir`=1 → A2B.
  - `en`=1, `dir`=0 → B2A.
  - `en`=0 → stay in IDLE.
  - No gap is applied from IDLE, because the block was not driving.
- **A2B**:
  - `en`=1, `dir`=1 → stay.
  - Otherwise (`en`=0 or `dir`=0) → TURN, loading the counter with TURNAROUND-1.
- **B2A**: symmetric to A2B; `en`=1, `dir`=0 stays, anything else → TURN.
- **TURN**:
  - If counter ≠ 0, decrement it and stay.
  - If counter = 0, sample `en`/`dir` at that edge: `en`=1 → A2B or B2A per `dir`; `en`=0 → IDLE.
  - Changes on `en`/`dir` during TURN are ignored until the final edge.
  - Returning to the same direction also pays the full gap.
- **Reset** (`rst_n` low): immediately, without waiting for a clock edge, the block enters IDLE and:
  - counter = 0
  - `q_ab` = `q_ba` = 0
  - `a_oe` = `b_oe` = `busy` = 0
  - `a` and `b` high-Z
- **Reset mid-drive** releases the bus in the same instant. After release, the first edge with `en`=1 enters a driving state directly.

## Timing
- **Latency**: one cycle. The value on the driven port after edge k equals the source port value sampled at edge k.
- **Enable from IDLE**: `en`/`dir` sampled at edge k → drive starts right after edge k.
- **Exit from a driving state**: request sampled at edge m.
  - The port is released right after edge m.
  - `busy` is high for exactly TURNAROUND cycles, edges m to m+TURNAROUND.
  - The next drive begins right after edge m+TURNAROUND at the earliest.
- **Gap guarantee**: `a_oe` and `b_oe` are never 1 simultaneously. Between any fall of one and rise of the other there are at least TURNAROUND full cycles.
- **Reset**: all outputs take their reset values asynchronously. Reset is released synchronously by the integrator.

## Test plan
- **Reset**: `rst_n`=0 with `en`=1 → `a`, `b` = Z; `a_oe`=`b_oe`=`busy`=0. Release with `en`=0 → remains in IDLE.
- **A→B pass**: `en`=1, `dir`=1, `a` sequence 8'h00,8'h5A,8'hA5,8'hFF → `b` shows each value one cycle later; `b_oe`=1; `a` is never driven by the DUT.
- **Reversal**: TURNAROUND=2, in A2B set `dir`=0 at edge 10 → `b` is Z after edge 10; `busy`=1 for edges 10–12; `a_oe` rises after edge 12; `a` = `b`@12.
- **Disable then opposite**: in B2A drop `en` at edge 5 → TURN for 2 cycles, then IDLE. Assert `en`=1, `dir`=1 at edge 9 → A2B immediately, with no extra gap.
- **Request churn in TURN**: toggle `dir`/`en` every cycle during TURN, final-edge values `en`=1, `dir`=1 → A2B. An assertion checks that `a_oe`&`b_oe` is never 1 over 500 random cycles.
- **Reset mid-drive, TURNAROUND=1**: assert `rst_n`=0 mid-cycle in A2B → `b` goes to Z with no clock. Separately, with TURNAROUND=1, a reversal gives exactly 1 `busy` cycle.

Source files
------------

// File: rtl/bidir_transceiver.sv
// Registered bidirectional bus transceiver between tri-state ports a and b.
// Every release of a driven port is followed by a high-Z turnaround gap.
module bidir_transceiver #(
  parameter int WIDTH      = 8,
  parameter int TURNAROUND = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  inout  tri   [WIDTH-1:0] a,
  inout  tri   [WIDTH-1:0] b,
  output logic             a_oe,
  output logic             b_oe,
  output logic             busy
);

  localparam int CW = $clog2(TURNAROUND + 1);
  localparam logic [CW-1:0] TLOAD = CW'(TURNAROUND - 1);

  typedef enum logic [1:0] {
    IDLE,
    A2B,
    B2A,
    TURN
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [WIDTH-1:0] q_ab;
  logic [WIDTH-1:0] q_ba;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: begin
        if (en) nxt = dir ? A2B : B2A;
      end
      A2B: begin
        if (!(en && dir)) begin
          nxt     = TURN;
          cnt_nxt = TLOAD;
        end
      end
      B2A: begin
        if (!(en && !dir)) begin
          nxt     = TURN;
          cnt_nxt = TLOAD;
        end
      end
      TURN: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          unique case (1'b1)
            (en && dir):  nxt = A2B;
            (en && !dir): nxt = B2A;
            default:      nxt = IDLE;
          endcase
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Output flags are registered from the next state, so they
  // always equal a decode of the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_oe  <= 1'b0;
      b_oe  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      a_oe  <= (nxt == B2A);
      b_oe  <= (nxt == A2B);
      busy  <= (nxt == TURN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ab <= '0;
      q_ba <= '0;
    end else begin
      q_ab <= a;
      q_ba <= b;
    end
  end

  assign b = b_oe ? q_ab : {WIDTH{1'bz}};
  assign a = a_oe ? q_ba : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bidir_transceiver.sv
// Directed vector table plus corner sequences for bidir_transceiver.
// A second instance covers TURNAROUND=1.
module tb_bidir_transceiver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic dir = 1'b0;
  logic ta_en = 1'b0;
  logic tb_en = 1'b0;
  logic [7:0] ta = 8'h00;
  logic [7:0] tbv = 8'h00;
  tri [7:0] a;
  tri [7:0] b;
  logic a_oe, b_oe, busy;

  logic en1 = 1'b0;
  logic dir1 = 1'b0;
  tri [3:0] a1;
  tri [3:0] b1;
  logic a1_oe, b1_oe, busy1;

  int total = 0;
  int bad = 0;

  assign a = ta_en ? ta : 8'hzz;
  assign b = tb_en ? tbv : 8'hzz;

  always #5 clk = ~clk;

  bidir_transceiver #(.WIDTH(8), .TURNAROUND(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir),
    .a(a), .b(b),
    .a_oe(a_oe), .b_oe(b_oe), .busy(busy)
  );

  bidir_transceiver #(.WIDTH(4), .TURNAROUND(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .dir(dir1),
    .a(a1), .b(b1),
    .a_oe(a1_oe), .b_oe(b1_oe), .busy(busy1)
  );

  always @(negedge clk) begin
    assert (!(a_oe && b_oe)) else $error("both ports driven");
    assert (!(a1_oe && b1_oe)) else $error("both ports driven dut1");
  end

  typedef struct {
    logic en, dir;
    logic ta_en; logic [7:0] ta;
    logic tb_en; logic [7:0] tbv;
    logic e_aoe, e_boe, e_busy;
    logic ck_a; logic [7:0] e_a;
    logic ck_b; logic [7:0] e_b;
  } vec_t;

  vec_t v[17];

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic e, d, ae, input logic [7:0] av,
    input logic be, input logic [7:0] bv,
    input logic xa, xb, xu,
    input logic ca, input logic [7:0] ea,
    input logic cb, input logic [7:0] eb);
    vec_t r;
    r.en = e; r.dir = d;
    r.ta_en = ae; r.ta = av;
    r.tb_en = be; r.tbv = bv;
    r.e_aoe = xa; r.e_boe = xb; r.e_busy = xu;
    r.ck_a = ca; r.e_a = ea;
    r.ck_b = cb; r.e_b = eb;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int brun;
  int idle_run;
  logic prev_oe;
  logic prev_busy;
  logic dropped;
  logic oe_now;

  initial begin
    v[0]  = mk(0,0, 1,8'h00, 1,8'h33, 0,0,0, 1,8'h00, 1,8'h33);
    v[1]  = mk(1,1, 1,8'h00, 0,8'h00, 0,1,0, 1,8'h00, 1,8'h00);
    v[2]  = mk(1,1, 1,8'h5A, 0,8'h00, 0,1,0, 1,8'h5A, 1,8'h5A);
    v[3]  = mk(1,1, 1,8'hA5, 0,8'h00, 0,1,0, 1,8'hA5, 1,8'hA5);
    v[4]  = mk(1,1, 1,8'hFF, 0,8'h00, 0,1,0, 1,8'hFF, 1,8'hFF);
    v[5]  = mk(1,0, 1,8'h3C, 0,8'h00, 0,0,1, 1,8'h3C, 0,8'h00);
    v[6]  = mk(1,0, 1,8'h77, 1,8'hC3, 0,0,1, 1,8'h77, 1,8'hC3);
    v[7]  = mk(1,0, 0,8'h00, 1,8'hC3, 1,0,0, 1,8'hC3, 1,8'hC3);
    v[8]  = mk(1,0, 0,8'h00, 1,8'h69, 1,0,0, 1,8'h69, 1,8'h69);
    v[9]  = mk(0,0, 0,8'h00, 1,8'h96, 0,0,1, 0,8'h00, 1,8'h96);
    v[10] = mk(0,0, 1,8'h12, 1,8'h34, 0,0,1, 1,8'h12, 1,8'h34);
    v[11] = mk(0,0, 1,8'h12, 1,8'h34, 0,0,0, 1,8'h12, 1,8'h34);
    v[12] = mk(1,1, 1,8'hAB, 0,8'h00, 0,1,0, 1,8'hAB, 1,8'hAB);
    v[13] = mk(0,1, 1,8'hCD, 0,8'h00, 0,0,1, 1,8'hCD, 0,8'h00);
    v[14] = mk(1,0, 1,8'hCD, 1,8'h55, 0,0,1, 1,8'hCD, 1,8'h55);
    v[15] = mk(1,1, 1,8'hE1, 0,8'h00, 0,1,0, 1,8'hE1, 1,8'hE1);
    v[16] = mk(1,1, 1,8'h0F, 0,8'h00, 0,1,0, 1,8'h0F, 1,8'h0F);

    // reset with en high: nothing may drive
    en = 1'b1; dir = 1'b1;
    ta_en = 1'b1; ta = 8'h11;
    tb_en = 1'b1; tbv = 8'h22;
    tick();
    tick();
    chk("rst_aoe", {7'd0, a_oe}, 8'd0);
    chk("rst_boe", {7'd0, b_oe}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_a", a, 8'h11);
    chk("rst_b", b, 8'h22);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    #4;

    for (int i = 0; i < 17; i++) begin
      en = v[i].en; dir = v[i].dir;
      ta_en = v[i].ta_en; ta = v[i].ta;
      tb_en = v[i].tb_en; tbv = v[i].tbv;
      tick();
      chk($sformatf("v%0d_aoe", i), {7'd0, a_oe}, {7'd0, v[i].e_aoe});
      chk($sformatf("v%0d_boe", i), {7'd0, b_oe}, {7'd0, v[i].e_boe});
      chk($sformatf("v%0d_busy", i), {7'd0, busy}, {7'd0, v[i].e_busy});
      if (v[i].ck_a) chk($sformatf("v%0d_a", i), a, v[i].e_a);
      if (v[i].ck_b) chk($sformatf("v%0d_b", i), b, v[i].e_b);
    end

    // asynchronous reset while driving b
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_boe", {7'd0, b_oe}, 8'd0);
    chk("mid_rst_aoe", {7'd0, a_oe}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    tb_en = 1'b1; tbv = 8'h5A;
    #1;
    chk("mid_rst_b", b, 8'h5A);
    chk("mid_rst_a", a, 8'h0F);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    tick();
    chk("post_rst_idle", {6'd0, a_oe, b_oe}, 8'd0);
    chk("post_rst_busy", {7'd0, busy}, 8'd0);
    en = 1'b1; dir = 1'b0;
    ta_en = 1'b0; tbv = 8'h42;
    tick();
    chk("post_rst_aoe", {7'd0, a_oe}, 8'd1);
    chk("post_rst_a", a, 8'h42);

    // TURNAROUND=1 reversal
    en1 = 1'b1; dir1 = 1'b1;
    tick();
    chk("t1_boe", {7'd0, b1_oe}, 8'd1);
    dir1 = 1'b0;
    tick();
    chk("t1_turn_busy", {7'd0, busy1}, 8'd1);
    chk("t1_turn_oe", {6'd0, a1_oe, b1_oe}, 8'd0);
    tick();
    chk("t1_end_busy", {7'd0, busy1}, 8'd0);
    chk("t1_aoe", {7'd0, a1_oe}, 8'd1);

    // random churn with buses released
    ta_en = 1'b0; tb_en = 1'b0;
    en = 1'b0;
    tick();
    tick();
    tick();
    brun = 0; idle_run = 3;
    prev_oe = 1'b0; prev_busy = 1'b0; dropped = 1'b0;
    for (int c = 0; c < 500; c++) begin
      en = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1));
      tick();
      oe_now = a_oe | b_oe;
      chk("rnd_overlap", {7'd0, a_oe & b_oe}, 8'd0);
      if (busy) begin
        brun++;
      end else if (prev_busy) begin
        chk("rnd_busy_len", 8'(brun), 8'd2);
        brun = 0;
      end
      if (oe_now && !prev_oe && dropped)
        chk("rnd_gap", {7'd0, idle_run >= 2}, 8'd1);
      if (!oe_now) idle_run = prev_oe ? 1 : idle_run + 1;
      if (prev_oe && !oe_now) dropped = 1'b1;
      prev_oe = oe_now;
      prev_busy = busy;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
